// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone bus arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package wb_arb_pkg;

  // Arbiter FSM: IDLE samples requests, BUSY forwards the owner to the slave.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Read data returned to the owner when the watchdog fires.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Supported master count range and the pointer width that covers it.
  localparam int MIN_MASTERS = 2;
  localparam int MAX_MASTERS = 4;
  localparam int PTR_W       = $clog2(MAX_MASTERS);

  // Index of the master after idx, wrapping at n.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: one-hot winner among requests, search starting at pointer.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the winner.
module rr_priority_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM = 2
) (
  input  logic [NUM-1:0]   req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NUM-1:0]   winner
);

  logic found;

  // Walk masters ptr, ptr+1, ... (mod NUM) and take the first one requesting.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      for (int j = 0; j < NUM; j++) begin
        if (!found && (j == (int'(ptr) + i) % NUM) && req[j]) begin
          winner[j] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Wishbone N:1 arbiter, round-robin, grant held for the whole m_cyc_i burst.
// Latency: 1 cycle request-to-grant; slave ack/data routed back with 0 added cycles.
// Backpressure: losers wait with no ack; WB_ARB_TIMEOUT_EN adds a stalled-strobe watchdog.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [NUM_MASTERS-1:0][3:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0][31:0] m_adr_i,
  input  logic [NUM_MASTERS-1:0][31:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [NUM_MASTERS-1:0][31:0] m_dat_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [3:0]                   s_sel_o,
  output logic [31:0]                  s_adr_o,
  output logic [31:0]                  s_dat_o,
  input  logic                         s_ack_i,
  input  logic [31:0]                  s_dat_i,
  output logic [NUM_MASTERS-1:0]       grant_o,
  output logic                         timeout_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] grant;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       owner_idx;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] winner;
  logic                   busy;
  logic                   owner_cyc;
  logic                   timeout_hit;

  assign req       = m_cyc_i & m_stb_i;
  // Reset in the same cycle already blocks any ack/err so an aborted transfer never completes.
  assign busy      = (state == BUSY) && !wb_rst_i;
  assign owner_cyc = |(m_cyc_i & grant);
  assign grant_o   = grant;

  rr_priority_picker #(
    .NUM    (NUM_MASTERS)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (winner)
  );

  // Binary index of the current owner, used to advance the round-robin pointer.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) owner_idx = PTR_W'(i);
    end
  end

  // Arbitration FSM: grant on any request in IDLE, release when the owner drops cyc.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_cyc) begin
            grant <= '0;
            ptr   <= rr_next(owner_idx, NUM_MASTERS);
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Forward the owner's bus signals to the slave; everything low when not busy.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (busy) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (grant[i]) begin
          s_cyc_o = m_cyc_i[i];
          s_stb_o = m_stb_i[i];
          s_we_o  = m_we_i[i];
          s_sel_o = m_sel_i[i];
          s_adr_o = m_adr_i[i];
          s_dat_o = m_dat_i[i];
        end
      end
    end
  end

  // Route slave ack/data (or the watchdog error) to the owner only.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (busy && grant[i]) begin
        m_ack_o[i] = s_ack_i;
        m_err_o[i] = timeout_hit;
        m_dat_o[i] = timeout_hit ? TIMEOUT_DATA : s_dat_i;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;

  // A late ack always wins over the watchdog, so hit requires no ack this cycle.
  assign timeout_hit = busy && s_stb_o && !s_ack_i && (to_cnt == TO_LAST);
  assign timeout_o   = timeout_hit;

  // Count consecutive stalled strobe cycles; any ack, idle strobe or expiry restarts it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_cnt <= '0;
    end else if (!busy || !s_stb_o || s_ack_i || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  // Without the watchdog a stalled owner simply waits forever.
  logic unused_cfg;
  assign unused_cfg  = ^TO_LAST;
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: cycle table plus timeout and reset sequences.
// Latency: checks 1-cycle grant and same-cycle ack routing.
// Backpressure: exercises stalled slave, held bursts and competing masters.
module tb_wb_bus_arbiter;

  localparam logic [31:0] ADR0 = 32'h3001_0004;
  localparam logic [31:0] ADR1 = 32'h4000_0010;

  logic             clk;
  logic             rst;
  logic [1:0]       m_cyc, m_stb, m_we;
  logic [1:0][3:0]  m_sel;
  logic [1:0][31:0] m_adr, m_wdat;
  logic [1:0]       m_ack, m_err;
  logic [1:0][31:0] m_rdat;
  logic             s_cyc, s_stb, s_we;
  logic [3:0]       s_sel;
  logic [31:0]      s_adr, s_wdat;
  logic             s_ack;
  logic [31:0]      s_rdat;
  logic [1:0]       grant;
  logic             tmo;

  int checks = 0;
  int errors = 0;

  wb_bus_arbiter #(
    .NUM_MASTERS    (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_sel_i   (m_sel),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_wdat),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .m_dat_o   (m_rdat),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_sel_o   (s_sel),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_wdat),
    .s_ack_i   (s_ack),
    .s_dat_i   (s_rdat),
    .grant_o   (grant),
    .timeout_o (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic        ack;
    logic [31:0] sdat;
    logic [1:0]  e_grant;
    logic        e_scyc;
    logic        e_sstb;
    logic        e_swe;
    logic [31:0] e_sadr;
    logic [1:0]  e_ack;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic [1:0] c, input logic [1:0] s,
                             input logic a, input logic [31:0] sd, input logic [1:0] eg,
                             input logic ec, input logic es, input logic ew,
                             input logic [31:0] ea, input logic [1:0] eack,
                             input logic [31:0] d0, input logic [31:0] d1);
    vec_t t;
    t.rst = r; t.cyc = c; t.stb = s; t.ack = a; t.sdat = sd;
    t.e_grant = eg; t.e_scyc = ec; t.e_sstb = es; t.e_swe = ew; t.e_sadr = ea;
    t.e_ack = eack; t.e_d0 = d0; t.e_d1 = d1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs shortly after the rising edge; caller samples 2ns later.
  task automatic drive(input logic r, input logic [1:0] c, input logic [1:0] s,
                       input logic a, input logic [31:0] sd);
    @(posedge clk);
    #2;
    rst = r; m_cyc = c; m_stb = s; s_ack = a; s_rdat = sd;
    #2;
  endtask

  initial begin
    m_we  = 2'b10;
    m_sel = {4'h3, 4'hF};
    m_adr = {ADR1, ADR0};
    m_wdat = {32'hB1B1_0001, 32'hA0A0_0000};
    rst = 1'b1; m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_rdat = '0;

    //        rst cyc    stb    ack sdat          grant  scyc  sstb  swe   sadr   ack    d0            d1
    // Master 0 alone: grant one cycle after request, acked on the third busy cycle.
    tbl.push_back(v(0, 2'b01, 2'b01, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 2'b00, 32'h0,        32'h0));
    tbl.push_back(v(0, 2'b01, 2'b01, 0, 32'h0,        2'b01, 1, 1, 0, ADR0,  2'b00, 32'h0,        32'h0));
    tbl.push_back(v(0, 2'b01, 2'b01, 0, 32'h0,        2'b01, 1, 1, 0, ADR0,  2'b00, 32'h0,        32'h0));
    tbl.push_back(v(0, 2'b01, 2'b01, 1, 32'h1234_5678, 2'b01, 1, 1, 0, ADR0, 2'b01, 32'h1234_5678, 32'h0));
    tbl.push_back(v(0, 2'b00, 2'b00, 0, 32'h0,        2'b01, 0, 0, 0, ADR0,  2'b00, 32'h0,        32'h0));
    tbl.push_back(v(0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 2'b00, 32'h0,        32'h0));
    // Reset, then both request together: master 0 first, then master 1.
    tbl.push_back(v(1, 2'b11, 2'b11, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 2'b00, 32'h0,        32'h0));
    tbl.push_back(v(0, 2'b11, 2'b11, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 2'b00, 32'h0,        32'h0));
    tbl.push_back(v(0, 2'b11, 2'b11, 1, 32'h0000_00AA, 2'b01, 1, 1, 0, ADR0, 2'b01, 32'h0000_00AA, 32'h0));
    tbl.push_back(v(0, 2'b10, 2'b10, 0, 32'h0,        2'b01, 0, 0, 0, ADR0,  2'b00, 32'h0,        32'h0));
    tbl.push_back(v(0, 2'b11, 2'b11, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 2'b00, 32'h0,        32'h0));
    // Master 1 holds cyc for four acked strobes while master 0 keeps requesting.
    tbl.push_back(v(0, 2'b11, 2'b11, 1, 32'h1,        2'b10, 1, 1, 1, ADR1,  2'b10, 32'h0,        32'h1));
    tbl.push_back(v(0, 2'b11, 2'b11, 1, 32'h2,        2'b10, 1, 1, 1, ADR1,  2'b10, 32'h0,        32'h2));
    tbl.push_back(v(0, 2'b11, 2'b01, 0, 32'h0,        2'b10, 1, 0, 1, ADR1,  2'b00, 32'h0,        32'h0));
    tbl.push_back(v(0, 2'b11, 2'b11, 1, 32'h3,        2'b10, 1, 1, 1, ADR1,  2'b10, 32'h0,        32'h3));
    tbl.push_back(v(0, 2'b11, 2'b11, 1, 32'h4,        2'b10, 1, 1, 1, ADR1,  2'b10, 32'h0,        32'h4));
    tbl.push_back(v(0, 2'b01, 2'b01, 0, 32'h0,        2'b10, 0, 0, 1, ADR1,  2'b00, 32'h0,        32'h0));
    tbl.push_back(v(0, 2'b01, 2'b01, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 2'b00, 32'h0,        32'h0));
    tbl.push_back(v(0, 2'b01, 2'b01, 1, 32'h55,       2'b01, 1, 1, 0, ADR0,  2'b01, 32'h55,       32'h0));
    tbl.push_back(v(0, 2'b00, 2'b00, 0, 32'h0,        2'b01, 0, 0, 0, ADR0,  2'b00, 32'h0,        32'h0));
    tbl.push_back(v(0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 2'b00, 32'h0,        32'h0));

    // Reset state.
    drive(1, 2'b00, 2'b00, 0, 32'h0);
    drive(0, 2'b00, 2'b00, 0, 32'h0);
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset s_cyc", 32'(s_cyc), 32'h0);
    chk("reset s_adr", s_adr, 32'h0);
    chk("reset ack", 32'(m_ack), 32'h0);
    chk("reset err", 32'(m_err), 32'h0);
    chk("reset timeout", 32'(tmo), 32'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].cyc, tbl[i].stb, tbl[i].ack, tbl[i].sdat);
      chk($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].e_grant));
      chk($sformatf("row%0d s_cyc", i), 32'(s_cyc), 32'(tbl[i].e_scyc));
      chk($sformatf("row%0d s_stb", i), 32'(s_stb), 32'(tbl[i].e_sstb));
      chk($sformatf("row%0d s_we", i), 32'(s_we), 32'(tbl[i].e_swe));
      chk($sformatf("row%0d s_adr", i), s_adr, tbl[i].e_sadr);
      chk($sformatf("row%0d ack", i), 32'(m_ack), 32'(tbl[i].e_ack));
      chk($sformatf("row%0d dat0", i), m_rdat[0], tbl[i].e_d0);
      chk($sformatf("row%0d dat1", i), m_rdat[1], tbl[i].e_d1);
      chk($sformatf("row%0d err", i), 32'(m_err), 32'h0);
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks: error and timeout pulse on the 8th stalled cycle.
    drive(0, 2'b01, 2'b01, 0, 32'h0);
    chk("to req grant", 32'(grant), 32'h0);
    for (int k = 1; k <= 9; k++) begin
      drive(0, 2'b01, 2'b01, 0, 32'h0);
      chk($sformatf("to c%0d grant", k), 32'(grant), 32'h1);
      chk($sformatf("to c%0d ack", k), 32'(m_ack), 32'h0);
      chk($sformatf("to c%0d err", k), 32'(m_err), (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("to c%0d timeout", k), 32'(tmo), (k == 8) ? 32'h1 : 32'h0);
      if (k == 8) chk("to dat0", m_rdat[0], 32'hDEAD_BEEF);
    end
    drive(0, 2'b00, 2'b00, 0, 32'h0);
    drive(0, 2'b00, 2'b00, 0, 32'h0);
    // Ack lands on the exact timeout cycle: ack only.
    drive(0, 2'b01, 2'b01, 0, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 2'b01, 2'b01, (k == 8), (k == 8) ? 32'h77 : 32'h0);
      chk($sformatf("co c%0d ack", k), 32'(m_ack), (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("co c%0d err", k), 32'(m_err), 32'h0);
      chk($sformatf("co c%0d timeout", k), 32'(tmo), 32'h0);
    end
    chk("co dat0", m_rdat[0], 32'h77);
    drive(0, 2'b00, 2'b00, 0, 32'h0);
    drive(0, 2'b00, 2'b00, 0, 32'h0);
`else
    // Without the watchdog a stalled owner waits indefinitely with no error.
    drive(0, 2'b01, 2'b01, 0, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      drive(0, 2'b01, 2'b01, 0, 32'h0);
      chk($sformatf("nto c%0d err", k), 32'(m_err), 32'h0);
      chk($sformatf("nto c%0d timeout", k), 32'(tmo), 32'h0);
      chk($sformatf("nto c%0d ack", k), 32'(m_ack), 32'h0);
    end
    chk("nto grant held", 32'(grant), 32'h1);
    chk("nto s_cyc held", 32'(s_cyc), 32'h1);
    drive(0, 2'b00, 2'b00, 0, 32'h0);
    drive(0, 2'b00, 2'b00, 0, 32'h0);
`endif

    // Reset in the middle of a BUSY transfer aborts it with no ack or err.
    drive(0, 2'b10, 2'b10, 0, 32'h0);
    drive(0, 2'b10, 2'b10, 0, 32'h0);
    chk("rst busy grant", 32'(grant), 32'h2);
    drive(1, 2'b10, 2'b10, 1, 32'h99);
    chk("rst cycle ack", 32'(m_ack), 32'h0);
    chk("rst cycle err", 32'(m_err), 32'h0);
    drive(0, 2'b10, 2'b10, 1, 32'h99);
    chk("post rst grant", 32'(grant), 32'h0);
    chk("post rst s_cyc", 32'(s_cyc), 32'h0);
    chk("post rst ack", 32'(m_ack), 32'h0);
    chk("post rst err", 32'(m_err), 32'h0);
    chk("post rst dat1", m_rdat[1], 32'h0);
    drive(0, 2'b00, 2'b00, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
